// File: rtl/wb_timeout_guard.sv
// Pipelined Wishbone guard between an interconnect slave port and a slave that may hang.
// Forwards traffic with zero latency and answers the master with err once the slave stops making progress.
module wb_timeout_guard #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADR_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_OUT        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_cyc,
    input  logic                s_stb,
    input  logic                s_we,
    input  logic [ADR_W-1:0]    s_adr,
    input  logic [DATA_W-1:0]   s_dat_w,
    input  logic [DATA_W/8-1:0] s_sel,
    output logic [DATA_W-1:0]   s_dat_r,
    output logic                s_ack,
    output logic                s_err,
    output logic                s_stall,
    output logic                m_cyc,
    output logic                m_stb,
    output logic                m_we,
    output logic [ADR_W-1:0]    m_adr,
    output logic [DATA_W-1:0]   m_dat_w,
    output logic [DATA_W/8-1:0] m_sel,
    input  logic [DATA_W-1:0]   m_dat_r,
    input  logic                m_ack,
    input  logic                m_err,
    input  logic                m_stall,
    output logic                timeout_irq,
    output logic [15:0]         timeout_cnt,
    output logic [ADR_W-1:0]    last_adr
);

    localparam int unsigned OUT_W  = $clog2(MAX_OUT + 1);
    localparam int unsigned PEND_W = OUT_W + 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {
        ST_PASS  = 1'b0,
        ST_ABORT = 1'b1
    } state_t;

    state_t              r_state;
    logic [OUT_W-1:0]    r_outstanding;
    logic [TMR_W-1:0]    r_timer;
    logic [PEND_W-1:0]   r_err_pend;
    logic                r_s_err;
    logic                r_irq;
    logic [15:0]         r_cnt;
    logic [ADR_W-1:0]    r_last_adr;
    logic [ADR_W-1:0]    r_acc_adr;

    logic                w_full;
    logic                w_busy;
    logic                w_accept;
    logic                w_resp;
    logic                w_tmr_run;
    logic                w_timeout;
    logic [PEND_W-1:0]   w_pend_nx;

    assign w_full    = (r_outstanding == OUT_W'(MAX_OUT));
    assign w_busy    = (r_outstanding != '0);
    assign w_accept  = s_cyc & s_stb & ~s_stall;
    assign w_resp    = (m_ack | m_err) & w_busy;
    assign w_tmr_run = s_cyc & (w_busy | s_stb);
    // Timeout only fires on a cycle where the timer would otherwise increment (no progress).
    assign w_timeout = (r_state == ST_PASS) & w_tmr_run & ~w_accept & ~w_resp
                     & (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign w_pend_nx = r_err_pend + PEND_W'(w_accept) - PEND_W'(r_s_err);

    assign m_we        = s_we;
    assign m_adr       = s_adr;
    assign m_dat_w     = s_dat_w;
    assign m_sel       = s_sel;
    assign timeout_irq = r_irq;
    assign timeout_cnt = r_cnt;
    assign last_adr    = r_last_adr;

    // Bus-facing handshake: transparent in PASS, guard-driven in ABORT.
    always_comb begin
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        s_stall = 1'b0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_dat_r = '0;
        if (r_state == ST_PASS) begin
            m_cyc   = s_cyc;
            m_stb   = s_stb & ~w_full;
            s_stall = m_stall | w_full;
            s_ack   = m_ack & w_busy;
            s_err   = m_err & w_busy;
            s_dat_r = m_dat_r;
        end else begin
            s_err   = r_s_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_PASS;
            r_outstanding <= '0;
            r_timer       <= '0;
            r_err_pend    <= '0;
            r_s_err       <= 1'b0;
            r_irq         <= 1'b0;
            r_cnt         <= '0;
            r_last_adr    <= '0;
            r_acc_adr     <= '0;
        end else begin
            r_irq <= w_timeout;
            if (w_accept) begin
                r_acc_adr <= s_adr;
            end
            if (w_timeout) begin
                r_last_adr <= r_acc_adr;
                if (r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            case (r_state)
                ST_PASS: begin
                    if (w_timeout) begin
                        r_state       <= ST_ABORT;
                        r_err_pend    <= PEND_W'(r_outstanding);
                        r_s_err       <= 1'b0;
                        r_outstanding <= '0;
                        r_timer       <= '0;
                    end else if (!s_cyc) begin
                        r_outstanding <= '0;
                        r_timer       <= '0;
                    end else begin
                        if (w_accept && !w_resp) begin
                            r_outstanding <= r_outstanding + OUT_W'(1);
                        end else if (!w_accept && w_resp) begin
                            r_outstanding <= r_outstanding - OUT_W'(1);
                        end
                        if (w_accept || w_resp || !w_tmr_run) begin
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                end
                ST_ABORT: begin
                    // Leaving ABORT discards any errors not yet delivered.
                    if (!s_cyc) begin
                        r_state    <= ST_PASS;
                        r_err_pend <= '0;
                        r_s_err    <= 1'b0;
                    end else begin
                        r_err_pend <= w_pend_nx;
                        r_s_err    <= (w_pend_nx != '0);
                    end
                    r_outstanding <= '0;
                    r_timer       <= '0;
                end
                default: r_state <= ST_PASS;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_timeout_guard.sv
// Directed bench for wb_timeout_guard with a short timeout (16 cycles) and MAX_OUT=4.
module tb_wb_timeout_guard;

    logic        clk;
    logic        rst_n;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic [3:0]  s_sel;
    logic        s_ack, s_err, s_stall;
    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_adr, m_dat_w, m_dat_r;
    logic [3:0]  m_sel;
    logic        m_ack, m_err, m_stall;
    logic        timeout_irq;
    logic [15:0] timeout_cnt;
    logic [31:0] last_adr;

    int checks = 0;
    int errors = 0;

    wb_timeout_guard #(
        .DATA_W(32), .ADR_W(32), .TIMEOUT_CYCLES(16), .MAX_OUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_sel(s_sel), .s_dat_r(s_dat_r),
        .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_dat_r(m_dat_r),
        .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall),
        .timeout_irq(timeout_irq), .timeout_cnt(timeout_cnt), .last_adr(last_adr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; s_cyc = 0; s_stb = 0; s_we = 0; s_adr = '0; s_dat_w = '0; s_sel = '0;
        m_dat_r = '0; m_ack = 0; m_err = 0; m_stall = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (timeout_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0h exp=0", timeout_cnt); end
        checks++; if (timeout_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%0b exp=0", timeout_irq); end
        checks++; if (last_adr !== 32'd0) begin errors++; $display("FAIL reset_last_adr got=%0h exp=0", last_adr); end
        checks++; if (s_err !== 1'b0 || s_stall !== 1'b0 || m_cyc !== 1'b0) begin
            errors++; $display("FAIL reset_bus got=err%0b stall%0b cyc%0b exp=000", s_err, s_stall, m_cyc); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        s_cyc = 1; s_stb = 1; s_we = 0; s_adr = 32'h0000_1000; s_sel = 4'hF;
        #1;
        checks++; if (m_cyc !== 1'b1 || m_stb !== 1'b1 || m_adr !== 32'h0000_1000 || s_stall !== 1'b0) begin
            errors++; $display("FAIL read_fwd got=cyc%0b stb%0b adr%0h stall%0b exp=cyc1 stb1 adr1000 stall0", m_cyc, m_stb, m_adr, s_stall); end
        tick();
        s_stb = 0;
        tick(); tick();
        m_ack = 1; m_dat_r = 32'hCAFE_F00D;
        #1;
        checks++; if (s_ack !== 1'b1 || s_dat_r !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL read_ack got=ack%0b dat%0h exp=ack1 datcafef00d", s_ack, s_dat_r); end
        tick();
        m_ack = 0; s_cyc = 0;
        tick();
        checks++; if (timeout_irq !== 1'b0 || timeout_cnt !== 16'd0) begin
            errors++; $display("FAIL read_noirq got=irq%0b cnt%0d exp=irq0 cnt0", timeout_irq, timeout_cnt); end
    endtask

    task automatic test_pipelined();
        s_cyc = 1; s_stb = 1; s_we = 1;
        for (int i = 0; i < 4; i++) begin
            s_adr = 32'h2000 + 32'(i * 4); s_dat_w = 32'(i);
            #1;
            checks++; if (s_stall !== 1'b0) begin errors++; $display("FAIL pipe_accept%0d stall got=%0b exp=0", i, s_stall); end
            tick();
        end
        s_adr = 32'h2010;
        #1;
        checks++; if (s_stall !== 1'b1 || m_stb !== 1'b0) begin
            errors++; $display("FAIL pipe_full got=stall%0b stb%0b exp=stall1 stb0", s_stall, m_stb); end
        tick();
        m_ack = 1;
        #1;
        checks++; if (s_ack !== 1'b1 || s_stall !== 1'b1) begin
            errors++; $display("FAIL pipe_first_ack got=ack%0b stall%0b exp=ack1 stall1", s_ack, s_stall); end
        tick();
        m_ack = 0;
        #1;
        checks++; if (s_stall !== 1'b0 || m_stb !== 1'b1) begin
            errors++; $display("FAIL pipe_unstall got=stall%0b stb%0b exp=stall0 stb1", s_stall, m_stb); end
        tick();
        s_stb = 0; m_ack = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (s_ack !== 1'b1) begin errors++; $display("FAIL pipe_drain%0d ack got=%0b exp=1", i, s_ack); end
            tick();
        end
        #1;
        checks++; if (s_ack !== 1'b0) begin errors++; $display("FAIL pipe_extra_ack got=%0b exp=0", s_ack); end
        tick();
        m_ack = 0; s_cyc = 0; s_we = 0;
        tick();
    endtask

    task automatic test_timeout_read();
        s_cyc = 1; s_stb = 1; s_adr = 32'h0000_3A3C;
        tick();
        s_stb = 0;
        for (int k = 1; k <= 16; k++) begin
            #1;
            checks++; if (timeout_irq !== 1'b0 || m_cyc !== 1'b1) begin
                errors++; $display("FAIL to_wait%0d got=irq%0b cyc%0b exp=irq0 cyc1", k, timeout_irq, m_cyc); end
            tick();
        end
        #1;
        checks++; if (timeout_irq !== 1'b1 || m_cyc !== 1'b0 || s_err !== 1'b0) begin
            errors++; $display("FAIL to_entry got=irq%0b cyc%0b err%0b exp=irq1 cyc0 err0", timeout_irq, m_cyc, s_err); end
        checks++; if (timeout_cnt !== 16'd1 || last_adr !== 32'h0000_3A3C) begin
            errors++; $display("FAIL to_stats got=cnt%0d adr%0h exp=cnt1 adr3a3c", timeout_cnt, last_adr); end
        tick();
        m_ack = 1;
        #1;
        checks++; if (s_err !== 1'b1 || s_ack !== 1'b0 || timeout_irq !== 1'b0) begin
            errors++; $display("FAIL to_err got=err%0b ack%0b irq%0b exp=err1 ack0 irq0", s_err, s_ack, timeout_irq); end
        tick();
        m_ack = 0;
        #1;
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL to_single_err got=%0b exp=0", s_err); end
        tick();
    endtask

    task automatic test_recover();
        s_cyc = 0;
        tick();
        m_ack = 1;
        #1;
        checks++; if (s_ack !== 1'b0) begin errors++; $display("FAIL rec_late_ack got=%0b exp=0", s_ack); end
        tick();
        m_ack = 0;
        s_cyc = 1; s_stb = 1; s_adr = 32'h0000_5550;
        #1;
        checks++; if (m_cyc !== 1'b1 || m_stb !== 1'b1) begin
            errors++; $display("FAIL rec_fwd got=cyc%0b stb%0b exp=11", m_cyc, m_stb); end
        tick();
        s_stb = 0; m_ack = 1; m_dat_r = 32'h1234_5678;
        #1;
        checks++; if (s_ack !== 1'b1 || s_dat_r !== 32'h1234_5678) begin
            errors++; $display("FAIL rec_read got=ack%0b dat%0h exp=ack1 dat12345678", s_ack, s_dat_r); end
        tick();
        m_ack = 0; s_cyc = 0;
        tick();
        checks++; if (timeout_cnt !== 16'd1) begin errors++; $display("FAIL rec_cnt got=%0d exp=1", timeout_cnt); end
    endtask

    task automatic test_stall_timeout();
        m_stall = 1; s_cyc = 1; s_stb = 1; s_adr = 32'h0000_7770;
        for (int j = 0; j < 16; j++) begin
            #1;
            checks++; if (s_stall !== 1'b1 || timeout_irq !== 1'b0) begin
                errors++; $display("FAIL st_wait%0d got=stall%0b irq%0b exp=stall1 irq0", j, s_stall, timeout_irq); end
            tick();
        end
        #1;
        checks++; if (timeout_irq !== 1'b1 || s_stall !== 1'b0 || m_cyc !== 1'b0 || m_stb !== 1'b0) begin
            errors++; $display("FAIL st_entry got=irq%0b stall%0b cyc%0b stb%0b exp=1000", timeout_irq, s_stall, m_cyc, m_stb); end
        checks++; if (timeout_cnt !== 16'd2 || last_adr !== 32'h0000_5550) begin
            errors++; $display("FAIL st_stats got=cnt%0d adr%0h exp=cnt2 adr5550", timeout_cnt, last_adr); end
        tick();
        s_stb = 0;
        #1;
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL st_err got=%0b exp=1", s_err); end
        tick();
        #1;
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL st_one_err_a got=%0b exp=0", s_err); end
        tick();
        #1;
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL st_one_err_b got=%0b exp=0", s_err); end
        s_cyc = 0; m_stall = 0;
        tick();
    endtask

    task automatic test_cyc_drop();
        s_cyc = 1; s_stb = 1; s_adr = 32'h0000_8000;
        tick();
        s_adr = 32'h0000_8004;
        tick();
        s_stb = 0;
        tick();
        s_cyc = 0;
        tick();
        m_ack = 1;
        #1;
        checks++; if (s_ack !== 1'b0) begin errors++; $display("FAIL drop_ack_idle got=%0b exp=0", s_ack); end
        tick();
        s_cyc = 1;
        #1;
        checks++; if (s_ack !== 1'b0) begin errors++; $display("FAIL drop_ack_newcyc got=%0b exp=0", s_ack); end
        tick();
        m_ack = 0;
        for (int k = 0; k < 20; k++) tick();
        checks++; if (timeout_irq !== 1'b0 || timeout_cnt !== 16'd2 || m_cyc !== 1'b1) begin
            errors++; $display("FAIL drop_no_abort got=irq%0b cnt%0d cyc%0b exp=irq0 cnt2 cyc1", timeout_irq, timeout_cnt, m_cyc); end
        s_cyc = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        s_cyc = 1; s_stb = 1; s_adr = 32'h0000_9990;
        tick();
        s_stb = 0;
        for (int k = 0; k < 16; k++) tick();
        checks++; if (timeout_cnt !== 16'd3 || m_cyc !== 1'b0) begin
            errors++; $display("FAIL rm_abort got=cnt%0d cyc%0b exp=cnt3 cyc0", timeout_cnt, m_cyc); end
        rst_n = 1'b0;
        #1;
        checks++; if (timeout_cnt !== 16'd0 || last_adr !== 32'd0 || m_cyc !== 1'b1 || s_err !== 1'b0) begin
            errors++; $display("FAIL rm_reset got=cnt%0d adr%0h cyc%0b err%0b exp=cnt0 adr0 cyc1 err0", timeout_cnt, last_adr, m_cyc, s_err); end
        tick();
        rst_n = 1'b1;
        m_ack = 1;
        #1;
        checks++; if (s_ack !== 1'b0) begin errors++; $display("FAIL rm_outstanding got=ack%0b exp=0", s_ack); end
        tick();
        m_ack = 0; s_cyc = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_pipelined();
        test_timeout_read();
        test_recover();
        test_stall_timeout();
        test_cyc_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
